alu_arbiter: RTL and testbench

//  Shares a single combinational alu (32-bit, 4-bit op_code) between two requesters.

---
 rtl/alu_arbiter_if.sv | 46 ++++
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals shared by the arbiter and its environment.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  // Two requesters, operands packed with requester i at slot i
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_x;
  logic [2*WIDTH-1:0] req_y;
  logic [2*OPW-1:0]   req_op;

  // Registered operands out to the ALU, combinational result back
  logic [WIDTH-1:0]   alu_x;
  logic [WIDTH-1:0]   alu_y;
  logic [OPW-1:0]     alu_op;
  logic [WIDTH-1:0]   alu_z;
  logic               alu_overflow;
  logic               alu_equal;
  logic               alu_zero;

  // Tagged response channel
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic [WIDTH-1:0]   resp_z;
  logic [2:0]         resp_flags;
  logic               resp_illegal;
  logic               busy;

  modport slave (
    input  req_valid, req_x, req_y, req_op,
    input  alu_z, alu_overflow, alu_equal, alu_zero,
    input  resp_ready,
    output req_ready, alu_x, alu_y, alu_op,
    output resp_valid, resp_id, resp_z, resp_flags, resp_illegal, busy
  );

  modport master (
    output req_valid, req_x, req_y, req_op,
    output alu_z, alu_overflow, alu_equal, alu_zero,
    output resp_ready,
    input  req_ready, alu_x, alu_y, alu_op,
    input  resp_valid, resp_id, resp_z, resp_flags, resp_illegal, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two requesters.
// One operation in flight at a time: IDLE accepts, EXEC lets the ALU settle, RESP holds the result.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic         clk,
  input  logic         rstb,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             id_reg;
  logic [WIDTH-1:0] alu_x_reg;
  logic [WIDTH-1:0] alu_y_reg;
  logic [OPW-1:0]   alu_op_reg;
  logic             resp_valid_reg;
  logic [WIDTH-1:0] resp_z_reg;
  logic [2:0]       resp_flags_reg;
  logic             resp_illegal_reg;

  logic [1:0]       grant;
  logic             accept;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic [OPW-1:0]   sel_op;

  // Reserved op codes: 0100 and 1011..1111
  function automatic logic is_reserved(input logic [OPW-1:0] op);
    return (op == OPW'(4'b0100)) || (op >= OPW'(4'b1011));
  endfunction

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept = |grant;
  assign sel_x  = grant[1] ? bus.req_x[WIDTH +: WIDTH] : bus.req_x[0 +: WIDTH];
  assign sel_y  = grant[1] ? bus.req_y[WIDTH +: WIDTH] : bus.req_y[0 +: WIDTH];
  assign sel_op = grant[1] ? bus.req_op[OPW +: OPW]    : bus.req_op[0 +: OPW];

  // Transaction FSM: latch operands on accept, capture ALU result after one settle cycle,
  // hold the response until the consumer takes it
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      id_reg           <= 1'b0;
      alu_x_reg        <= '0;
      alu_y_reg        <= '0;
      alu_op_reg       <= '0;
      resp_valid_reg   <= 1'b0;
      resp_z_reg       <= '0;
      resp_flags_reg   <= 3'b000;
      resp_illegal_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_x_reg  <= sel_x;
            alu_y_reg  <= sel_y;
            alu_op_reg <= sel_op;
            id_reg     <= grant[1];
            last_grant <= grant[1];
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_z_reg       <= bus.alu_z;
          resp_flags_reg   <= {bus.alu_overflow, bus.alu_equal, bus.alu_zero};
          resp_illegal_reg <= is_reserved(alu_op_reg);
          resp_valid_reg   <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = grant;
  assign bus.alu_x        = alu_x_reg;
  assign bus.alu_y        = alu_y_reg;
  assign bus.alu_op       = alu_op_reg;
  assign bus.resp_valid   = resp_valid_reg;
  assign bus.resp_id      = id_reg;
  assign bus.resp_z       = resp_z_reg;
  assign bus.resp_flags   = resp_flags_reg;
  assign bus.resp_illegal = resp_illegal_reg;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed requests against a scoreboard and a behavioural ALU.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  typedef struct { logic [31:0] x; logic [31:0] y; logic [3:0] op; } req_t;
  typedef struct {
    bit id; logic [31:0] x; logic [31:0] y; logic [31:0] z;
    logic [3:0] op; logic [2:0] flags; bit illegal; int acc_cycle;
  } exp_t;
  typedef struct packed { logic [31:0] z; logic ov; logic eq; logic zr; } alu_res_t;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();
  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (.clk(clk), .rstb(rstb), .bus(bus));

  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;
  int   hs_count [2] = '{0, 0};
  int   seen [2]     = '{0, 0};
  int   hold_left    = 0;
  bit   in_flight    = 0;
  bit   last_served  = 1;
  bit   resp_seen    = 0;
  bit   resp_vis     = 0;
  bit   after_rst    = 0;
  exp_t sb [$];
  req_t pend0 [$];
  req_t pend1 [$];

  function automatic bit rsv(input logic [3:0] op);
    return op inside {4'b0100, [4'b1011:4'b1111]};
  endfunction

  // Behavioural ALU: reserved ops drive everything to zero
  function automatic alu_res_t alu_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    alu_res_t r;
    logic [31:0] z;
    logic ov;
    z  = '0;
    ov = 1'b0;
    if (rsv(op)) return '0;
    case (op)
      4'h0: z = x & y;
      4'h1: z = x | y;
      4'h2: z = x ^ y;
      4'h3: z = ~(x | y);
      4'h5: begin z = x + y; ov = (x[31] == y[31]) && (z[31] != x[31]); end
      4'h6: begin z = x - y; ov = (x[31] != y[31]) && (z[31] != x[31]); end
      4'h7: z = {31'b0, ($signed(x) < $signed(y))};
      4'h8: z = x << y[4:0];
      4'h9: z = x >> y[4:0];
      default: z = x;
    endcase
    r.z  = z;
    r.ov = ov;
    r.eq = (x == y);
    r.zr = (z == 32'd0);
    return r;
  endfunction

  alu_res_t alu_env;
  always_comb alu_env = alu_model(bus.alu_op, bus.alu_x, bus.alu_y);
  assign bus.alu_z        = alu_env.z;
  assign bus.alu_overflow = alu_env.ov;
  assign bus.alu_equal    = alu_env.eq;
  assign bus.alu_zero     = alu_env.zr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, want, cycle);
    end
  endtask

  // Monitor / scoreboard: predicts grants, pushes expected responses, checks DUT outputs
  initial begin
    exp_t       ex;
    alu_res_t   ar;
    logic [1:0] want_rdy;
    bit         id;
    forever begin
      @(negedge clk or negedge rstb);
      if (!rstb) begin
        #1;
        chk("rst_alu_xy", {bus.alu_x, bus.alu_y}, 64'd0);
        chk("rst_resp", {26'd0, bus.resp_z, bus.resp_flags, bus.resp_illegal, bus.resp_id, bus.resp_valid}, 64'd0);
        chk("rst_ctl", {57'd0, bus.req_ready, bus.alu_op, bus.busy}, 64'd0);
        sb.delete();
        in_flight   = 0;
        last_served = 1;
        resp_seen   = 0;
        resp_vis    = 0;
        after_rst   = 1;
      end else begin
        want_rdy = 2'b00;
        if (!in_flight) begin
          if (bus.req_valid == 2'b01)      want_rdy = 2'b01;
          else if (bus.req_valid == 2'b10) want_rdy = 2'b10;
          else if (bus.req_valid == 2'b11) want_rdy = (last_served == 1'b0) ? 2'b10 : 2'b01;
        end
        chk("req_ready", {62'd0, bus.req_ready}, {62'd0, want_rdy});
        chk("busy", {63'd0, bus.busy}, {63'd0, in_flight});
        if (want_rdy != 2'b00) begin
          id = want_rdy[1];
          if (after_rst && bus.req_valid == 2'b11)
            chk("tie_after_reset", {62'd0, bus.req_ready}, 64'd1);
          after_rst    = 0;
          ex.id        = id;
          ex.x         = id ? bus.req_x[63:32] : bus.req_x[31:0];
          ex.y         = id ? bus.req_y[63:32] : bus.req_y[31:0];
          ex.op        = id ? bus.req_op[7:4]  : bus.req_op[3:0];
          ar           = alu_model(ex.op, ex.x, ex.y);
          ex.z         = ar.z;
          ex.flags     = {ar.ov, ar.eq, ar.zr};
          ex.illegal   = rsv(ex.op);
          ex.acc_cycle = cycle;
          sb.push_back(ex);
          in_flight    = 1;
          last_served  = id;
          hs_count[id] = hs_count[id] + 1;
        end
        resp_vis = bus.resp_valid;
        if (bus.resp_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_unexpected: got resp_valid=1 want 0 (cycle %0d)", cycle);
          end else begin
            ex = sb[0];
            $display("resp id=%0d op=%h x=%h y=%h z=%h flags=%b illegal=%0d ready=%0d",
                     bus.resp_id, bus.alu_op, bus.alu_x, bus.alu_y, bus.resp_z, bus.resp_flags,
                     bus.resp_illegal, bus.resp_ready);
            chk("resp_id", {63'd0, bus.resp_id}, {63'd0, ex.id});
            chk("resp_z", {32'd0, bus.resp_z}, {32'd0, ex.z});
            chk("resp_flags", {61'd0, bus.resp_flags}, {61'd0, ex.flags});
            chk("resp_illegal", {63'd0, bus.resp_illegal}, {63'd0, ex.illegal});
            chk("alu_xy", {bus.alu_x, bus.alu_y}, {ex.x, ex.y});
            chk("alu_op", {60'd0, bus.alu_op}, {60'd0, ex.op});
            if (!resp_seen) begin
              chk("latency", 64'(cycle), 64'(ex.acc_cycle + 2));
              resp_seen = 1;
            end
            if (bus.resp_ready) begin
              void'(sb.pop_front());
              in_flight = 0;
              resp_seen = 0;
            end
          end
        end
        cycle++;
      end
    end
  end

  task automatic push(input int id, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    req_t r;
    r.x = x;
    r.y = y;
    r.op = op;
    if (id == 0) pend0.push_back(r);
    else         pend1.push_back(r);
  endtask

  // One driver cycle: retire accepted requests, present next ones, set resp_ready
  task automatic step(input bit wd, input bit rr);
    logic [1:0]  v;
    logic [63:0] xs;
    logic [63:0] ys;
    logic [7:0]  ops;
    @(posedge clk);
    #1;
    if (hs_count[0] != seen[0]) begin
      seen[0] = hs_count[0];
      if (pend0.size() > 0) void'(pend0.pop_front());
    end
    if (hs_count[1] != seen[1]) begin
      seen[1] = hs_count[1];
      if (pend1.size() > 0) void'(pend1.pop_front());
    end
    v   = 2'b00;
    xs  = {$urandom, $urandom};
    ys  = {$urandom, $urandom};
    ops = 8'($urandom);
    if (pend0.size() > 0 && !(wd && $urandom_range(0, 5) == 0)) begin
      v[0] = 1'b1; xs[31:0] = pend0[0].x; ys[31:0] = pend0[0].y; ops[3:0] = pend0[0].op;
    end
    if (pend1.size() > 0 && !(wd && $urandom_range(0, 5) == 0)) begin
      v[1] = 1'b1; xs[63:32] = pend1[0].x; ys[63:32] = pend1[0].y; ops[7:4] = pend1[0].op;
    end
    bus.req_valid = v;
    bus.req_x     = xs;
    bus.req_y     = ys;
    bus.req_op    = ops;
    if (resp_vis && hold_left > 0) hold_left--;
    bus.resp_ready = (hold_left > 0) ? 1'b0 : (rr ? ($urandom_range(0, 2) != 0) : 1'b1);
  endtask

  task automatic drain(input bit wd, input bit rr);
    int n;
    n = 0;
    while (pend0.size() + pend1.size() > 0 || in_flight || sb.size() > 0) begin
      step(wd, rr);
      n++;
      if (n > 3000) begin
        $display("FAIL drain_timeout: got pending=%0d want 0", pend0.size() + pend1.size() + sb.size());
        $fatal(1, "drain timeout");
      end
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 7));
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Stimulus sequence
  initial begin
    int h0;
    int n;
    logic [31:0] rx;
    bus.req_valid  = 2'b00;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    #2 rstb = 1'b0;
    repeat (3) @(posedge clk);
    #3 rstb = 1'b1;

    // Single add from requester 0
    push(0, 32'd5, 32'd7, 4'b0101);
    drain(0, 0);

    // Both requesters busy back to back: grants must alternate
    push(0, 32'd10, 32'd3, 4'b0110);
    push(1, 32'hF0F0_0000, 32'h0F0F_0000, 4'b0001);
    push(0, 32'd1, 32'd4, 4'b1000);
    push(1, 32'd9, 32'd9, 4'b0010);
    drain(0, 0);

    // Signed overflow from requester 1
    push(1, 32'h7FFF_FFFF, 32'd1, 4'b0101);
    drain(0, 0);

    // Consumer stalls the response for three cycles
    hold_left = 3;
    push(0, 32'd100, 32'd23, 4'b0110);
    drain(0, 0);

    // Reserved op
    push(0, 32'd3, 32'd3, 4'b1100);
    drain(0, 1);

    // Reset while the ALU is settling: transaction dropped, requester 0 wins the next tie
    push(0, 32'd9, 32'd4, 4'b0110);
    h0 = hs_count[0];
    n  = 0;
    while (hs_count[0] == h0) begin
      step(0, 1);
      n++;
      if (n > 50) begin
        $display("FAIL accept_timeout: got no accept want accept");
        $fatal(1, "accept timeout");
      end
    end
    #1 rstb = 1'b0;
    pend0.delete();
    pend1.delete();
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #3 rstb = 1'b1;
    seen[0] = hs_count[0];
    seen[1] = hs_count[1];
    push(0, 32'd2, 32'd2, 4'b0101);
    push(1, 32'd8, 32'd1, 4'b1001);
    drain(0, 1);

    // Random traffic with withdrawals and random response back-pressure
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && pend0.size() < 2) begin
        rx = rand_word();
        push(0, rx, ($urandom_range(0, 3) == 0) ? rx : rand_word(), 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 2) == 0 && pend1.size() < 2) begin
        rx = rand_word();
        push(1, rx, ($urandom_range(0, 3) == 0) ? rx : rand_word(), 4'($urandom_range(0, 15)));
      end
      step(1, 1);
    end
    drain(1, 1);
    repeat (3) step(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
